program_loader: RTL and testbench
=================================

# program_loader

Boot-time writer for the MiniAlu instruction memory. It receives a framed byte stream and assembles 28-bit instruction words. It writes them to consecutive instruction-memory addresses and holds the CPU in reset until a complete, checksum-verified program has landed. It sits between the byte source (UART receiver or test stimulus) and the write port of a writable instruction memory that replaces the fixed ROM.

## Interface
- MAX_WORDS, 256, largest accepted instruction count N; a larger frame is rejected.
- Clock  in  1  system clock, all state changes on rising edge.
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clock.
- iByteValid  in  1  iByte holds a valid byte this cycle.
- iByte  in  8  incoming stream byte.
- oByteReady  out  1  loader can accept a byte; transfer occurs when iByteValid && oByteReady at a rising edge.
- oWriteEnable  out  1  one-cycle instruction-memory write strobe.
- oWriteAddress  out  16  instruction address (word index), same width as the CPU IP.
- oInstruction  out  28  instruction word, with opcode in [27:24], destination in [23:16], src1 in [15:8], src0 in [7:0].
- oCpuReset  out  1  drive into the CPU Reset; high except when a valid program is loaded.
- oDone  out  1  program loaded and verified.
- oError  out  1  last frame rejected.

## Operation
- Frame format: 0xA5, N[15:8], N[7:0], then N words of 4 bytes each, MSB first, then a checksum byte.
  - The checksum is the XOR of all 4N word bytes.
- Word byte 0 carries only instruction bits [27:24]. Its upper nibble must be 0.
- States and transitions:
  - IDLE: discard every byte except 0xA5. On 0xA5, go to LEN_H.
  - LEN_H: latch N[15:8], go to LEN_L.
  - LEN_L: latch N[7:0].
    - If N > MAX_WORDS, go to ERROR.
    - If N == 0, go to CHECK.
    - Otherwise go to DATA, with word index 0, byte count 0, and checksum 0.
  - DATA: shift each byte into the assembly register and XOR it into the running checksum.
    - If byte 0 has a nonzero upper nibble, go to ERROR immediately; that word is not written.
    - On byte 3: issue a write at the current word index, then increment the index.
    - When the index reaches N, go to CHECK.
  - CHECK: the received byte is compared with the running checksum. Equal → DONE, unequal → ERROR.
  - DONE: oDone=1, oCpuReset=0. A byte 0xA5 starts a new frame: go to LEN_H, with oDone=0 and oCpuReset=1 from the next cycle. Other bytes are ignored.
  - ERROR: oError=1, oCpuReset=1. A byte 0xA5 clears oError and goes to LEN_H. Other bytes are ignored.
- oByteReady is 1 in every state. The loader never stalls the source.
- Byte counter: 2 bits, wraps 3→0 at each word. Word index: 16 bits, never exceeds MAX_WORDS.
- Instruction memory contents after an ERROR are undefined. The CPU is kept in reset, so this is harmless.

## Timing
- Reset values:
  - state IDLE
  - oCpuReset=1, oDone=0, oError=0
  - oWriteEnable=0, oWriteAddress=0, oInstruction=0
  - oByteReady=0 during the reset cycle, 1 afterwards.
- All outputs are registered.
- oWriteEnable pulses for exactly one cycle, in the cycle after byte 3 of a word is accepted. oWriteAddress and oInstruction are valid in that same cycle and hold their values until the next write.
- oDone rises and oCpuReset falls together, in the cycle after the checksum byte is accepted. The CPU's first fetch is from address 0, one cycle later.
- oError rises in the cycle after the offending byte.
- Back-to-back bytes (iByteValid held high) are accepted at one per cycle, so a word takes 4 cycles and there is at most one write per 4 cycles. Gaps in iByteValid simply stall progress. No timeout.
- Reset asserted in any state, including mid-word, takes precedence:
  - It returns to IDLE and discards the partial word. No write is issued.
  - oDone and oError clear; oCpuReset=1.

## Test plan
- Reset, then send A5 00 02 01 00 00 05 02 03 00 07 02 back-to-back.
  - Required: writes addr0=0x1000005 and addr1=0x2030007, each a one-cycle strobe.
  - Then oDone=1 and oCpuReset=0, one cycle after the byte 02.
- Same frame with checksum 03.
  - Required: both writes occur, oError=1, oDone=0, oCpuReset stays 1.
  - Then resend the correct frame: oError clears and oDone=1.
- Garbage 00 FF 5A 13, then A5 00 00 00 (N=0).
  - Required: garbage is ignored, there are no writes, and oDone=1.
- A5 01 01 (N=257 > 256).
  - Required: ERROR one cycle after the third byte. Following data bytes produce no writes.
- A5 00 01 10 00 00 00.
  - Required: nonzero nibble, so ERROR after byte 0x10. No write is issued.
- A5 00 01 01 00, then Reset for one cycle.
  - Required: IDLE, no write, oCpuReset=1.
  - Then the frame A5 00 01 01 00 00 05 04, with iByteValid toggling every other cycle: a single write addr0=0x1000005, then oDone=1.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader for the MiniAlu instruction memory: parses a framed byte stream,
// writes 28-bit words to consecutive addresses and releases the CPU once the checksum matches.
module program_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iByteValid,
  input  logic [7:0]  iByte,
  output logic        oByteReady,
  output logic        oWriteEnable,
  output logic [15:0] oWriteAddress,
  output logic [27:0] oInstruction,
  output logic        oCpuReset,
  output logic        oDone,
  output logic        oError
);

  // state   | meaning
  // IDLE    | hunting for the 0xA5 frame marker
  // LEN_H   | next byte is N[15:8]
  // LEN_L   | next byte is N[7:0]; range-checked against MAX_WORDS
  // DATA    | assembling 4-byte words and writing them out
  // CHECK   | next byte is the XOR checksum of all word bytes
  // DONE    | program verified, CPU released
  // ERROR   | frame rejected, CPU held in reset
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [19:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [27:0] instr_q, instr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cpurst_q, cpurst_d;
  logic        rdy_q;
  logic        accept;
  logic [15:0] len_full;

  assign accept   = iByteValid && rdy_q;
  assign len_full = {len_q[15:8], iByte};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    instr_d = instr_q;
    if (accept) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: if (iByte == 8'hA5) state_d = S_LEN_H;
        S_LEN_H: begin
          len_d   = {iByte, 8'h00};
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          len_d  = len_full;
          idx_d  = 16'd0;
          bcnt_d = 2'd0;
          csum_d = 8'h00;
          if (len_full > MAX_N)       state_d = S_ERROR;
          else if (len_full == 16'd0) state_d = S_CHECK;
          else                        state_d = S_DATA;
        end
        S_DATA: begin
          csum_d = csum_q ^ iByte;
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: begin
              // Only the opcode nibble is meaningful in the first word byte.
              if (iByte[7:4] != 4'h0) state_d = S_ERROR;
              else                    asm_d = {iByte[3:0], 16'h0000};
            end
            2'd1: asm_d[15:8] = iByte;
            2'd2: asm_d[7:0]  = iByte;
            default: begin
              we_d    = 1'b1;
              addr_d  = idx_q;
              instr_d = {asm_q, iByte};
              idx_d   = idx_q + 16'd1;
              if (idx_q + 16'd1 == len_q) state_d = S_CHECK;
            end
          endcase
        end
        S_CHECK: state_d = (iByte == csum_q) ? S_DONE : S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERROR);
    cpurst_d = (state_d != S_DONE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      len_q    <= 16'd0;
      idx_q    <= 16'd0;
      bcnt_q   <= 2'd0;
      asm_q    <= 20'd0;
      csum_q   <= 8'h00;
      we_q     <= 1'b0;
      addr_q   <= 16'd0;
      instr_q  <= 28'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cpurst_q <= 1'b1;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      csum_q   <= csum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cpurst_q <= cpurst_d;
      rdy_q    <= 1'b1;
    end
  end

  assign oByteReady    = rdy_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oInstruction  = instr_q;
  assign oCpuReset     = cpurst_q;
  assign oDone         = done_q;
  assign oError        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames are generated from word lists, expected
// writes are queued from the frame contents and a monitor checks every write strobe.
module tb_program_loader;
  logic        Clock = 1'b0;
  logic        Reset;
  logic        iByteValid;
  logic [7:0]  iByte;
  logic        oByteReady, oWriteEnable, oCpuReset, oDone, oError;
  logic [15:0] oWriteAddress;
  logic [27:0] oInstruction;

  program_loader #(.MAX_WORDS(256)) dut (
    .Clock(Clock), .Reset(Reset), .iByteValid(iByteValid), .iByte(iByte),
    .oByteReady(oByteReady), .oWriteEnable(oWriteEnable),
    .oWriteAddress(oWriteAddress), .oInstruction(oInstruction),
    .oCpuReset(oCpuReset), .oDone(oDone), .oError(oError)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0] a;
    logic [27:0] w;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic        prev_we = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [27:0] fixed_w[2] = '{28'h1000005, 28'h2030007};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (!Reset) begin
      if (oWriteEnable) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", oWriteAddress, oInstruction);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", 32'(oWriteAddress), 32'(mon_e.a));
          chk("write_data", 32'(oInstruction), 32'(mon_e.w));
        end
        chk("write_one_cycle", 32'(prev_we), 32'd0);
      end
      prev_we = oWriteEnable;
    end else prev_we = 1'b0;
  end

  function automatic logic [7:0] rand_nona5();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'hA5);
    return b;
  endfunction

  task automatic send(input logic [7:0] b, input bit toggle);
    if (toggle) begin
      @(negedge Clock); iByteValid = 1'b0; iByte = 8'hA5;
      @(posedge Clock);
    end
    @(negedge Clock); iByteValid = 1'b1; iByte = b;
    @(posedge Clock);
  endtask

  task automatic settle();
    @(negedge Clock); iByteValid = 1'b0; iByte = 8'($urandom);
  endtask

  task automatic status(input string tag, input bit done, input bit err);
    chk({tag, "_done"}, 32'(oDone), 32'(done));
    chk({tag, "_error"}, 32'(oError), 32'(err));
    chk({tag, "_cpu_reset"}, 32'(oCpuReset), 32'(!done));
    chk({tag, "_ready"}, 32'(oByteReady), 32'd1);
  endtask

  // Sends one frame; bad_word < 0 means every word has a legal first byte.
  task automatic send_frame(input int n, input int bad_word, input bit bad_csum,
                            input bit toggle, input bit fixed);
    logic [7:0]  cs;
    logic [27:0] w;
    cs = 8'h00;
    send(8'hA5, toggle);
    send(8'(n >> 8), toggle);
    send(8'(n), toggle);
    if (n > 256) begin
      settle();
      status("oversize", 1'b0, 1'b1);
      repeat (3) send(rand_nona5(), toggle);
      settle();
      status("oversize_tail", 1'b0, 1'b1);
      chk("oversize_no_writes", 32'(exp_q.size()), 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = fixed ? fixed_w[i] : 28'($urandom);
      if (i == bad_word) begin
        send({4'($urandom_range(1, 15)), w[27:24]}, toggle);
        settle();
        status("bad_nibble", 1'b0, 1'b1);
        chk("bad_nibble_writes", 32'(exp_q.size()), 32'd0);
        return;
      end
      exp_q.push_back('{16'(i), w});
      send({4'h0, w[27:24]}, toggle);
      send(w[23:16], toggle);
      send(w[15:8], toggle);
      send(w[7:0], toggle);
      cs = cs ^ {4'h0, w[27:24]} ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    if (bad_csum) cs = cs ^ 8'($urandom_range(1, 255));
    if (toggle) begin
      @(negedge Clock); iByteValid = 1'b0;
      @(posedge Clock);
    end
    @(negedge Clock);
    chk("pre_csum_done", 32'(oDone), 32'd0);
    chk("pre_csum_cpu_reset", 32'(oCpuReset), 32'd1);
    iByteValid = 1'b1; iByte = cs;
    @(posedge Clock);
    settle();
    status("frame_end", !bad_csum, bad_csum);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n, bw;
    bit bc, tg;
    Reset = 1'b1; iByteValid = 1'b0; iByte = 8'h00;
    @(negedge Clock);
    chk("reset_ready", 32'(oByteReady), 32'd0);
    chk("reset_cpu_reset", 32'(oCpuReset), 32'd1);
    chk("reset_done", 32'(oDone), 32'd0);
    chk("reset_error", 32'(oError), 32'd0);
    chk("reset_we", 32'(oWriteEnable), 32'd0);
    chk("reset_addr", 32'(oWriteAddress), 32'd0);
    chk("reset_instr", 32'(oInstruction), 32'd0);
    Reset = 1'b0;

    send_frame(2, -1, 1'b0, 1'b0, 1'b1);
    send_frame(2, -1, 1'b1, 1'b0, 1'b1);
    send_frame(2, -1, 1'b0, 1'b0, 1'b1);

    send(8'h00, 1'b0); send(8'hFF, 1'b0); send(8'h5A, 1'b0); send(8'h13, 1'b0);
    settle();
    status("garbage", 1'b1, 1'b0);
    send_frame(0, -1, 1'b0, 1'b0, 1'b0);

    send_frame(257, -1, 1'b0, 1'b0, 1'b0);
    send_frame(1, 0, 1'b0, 1'b0, 1'b0);

    send(8'hA5, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
    send(8'h01, 1'b0); send(8'h00, 1'b0);
    settle();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("midword_reset_ready", 32'(oByteReady), 32'd0);
    chk("midword_reset_cpu_reset", 32'(oCpuReset), 32'd1);
    chk("midword_reset_error", 32'(oError), 32'd0);
    chk("midword_reset_done", 32'(oDone), 32'd0);
    send_frame(1, -1, 1'b0, 1'b1, 1'b1);

    send_frame(256, -1, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 16; f++) begin
      repeat ($urandom_range(0, 3)) send(rand_nona5(), 1'b0);
      n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 600)) : int'($urandom_range(0, 6));
      bw = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      bc = ($urandom_range(0, 3) == 0);
      tg = ($urandom_range(0, 2) == 0);
      send_frame(n, bw, bc, tg, 1'b0);
    end

    settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
